// File: rtl/pixie_dma_scheduler.sv
// CDP1861 (Pixie) line/frame timing and DMA-OUT sequencer.
// Runs on CPU machine cycles (ce) and forwards fetched bytes to the row buffer.
module pixie_dma_scheduler #(
   parameter int CYCLES_PER_LINE = 14,
   parameter int LINES_PER_FRAME = 262,
   parameter int FIRST_ACTIVE    = 64,
   parameter int ACTIVE_LINES    = 128,
   parameter int BYTES_PER_LINE  = 8,
   parameter int DMA_START_CYC   = 2,
   parameter int INT_LINES       = 2,
   parameter int EF_LINES        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [1:0] sc,
   input  logic       disp_on,
   input  logic       disp_off,
   input  logic [7:0] data_in,
   output logic       dma_out_n,
   output logic       int_req,
   output logic       efx_n,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic [2:0] byte_col,
   output logic [6:0] byte_row,
   output logic       line_start,
   output logic       frame_start,
   output logic [3:0] hcount,
   output logic [8:0] vcount,
   output logic       display_enabled,
   output logic       dma_short
);

   localparam logic [3:0] H_LAST  = 4'(CYCLES_PER_LINE - 1);
   localparam logic [3:0] H_DMA   = 4'(DMA_START_CYC);
   localparam logic [8:0] V_LAST  = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0] V_FIRST = 9'(FIRST_ACTIVE);
   localparam logic [8:0] V_END   = 9'(FIRST_ACTIVE + ACTIVE_LINES);
   localparam logic [8:0] INT_LO  = 9'(FIRST_ACTIVE - INT_LINES);
   localparam logic [8:0] EF1_LO  = 9'(FIRST_ACTIVE - EF_LINES);
   localparam logic [8:0] EF2_LO  = 9'(FIRST_ACTIVE + ACTIVE_LINES - EF_LINES);
   localparam logic [2:0] ACK_LAST = 3'(BYTES_PER_LINE - 1);
   localparam logic [6:0] ROW_OFS = 7'(FIRST_ACTIVE);

   typedef enum logic {IDLE, REQ} state_t;

   state_t     state;
   logic       pending;
   logic [2:0] ack_cnt;
   logic       wrap;
   logic       active;
   logic       de_nxt;
   logic       ack;
   logic [3:0] h_nxt;
   logic [8:0] v_nxt;

   always_comb begin
      wrap   = (hcount == H_LAST);
      h_nxt  = wrap ? 4'd0 : hcount + 4'd1;
      v_nxt  = vcount;
      if (wrap)
         v_nxt = (vcount == V_LAST) ? 9'd0 : vcount + 9'd1;
      de_nxt = wrap ? pending : display_enabled;
      active = display_enabled && (vcount >= V_FIRST) && (vcount < V_END);
      ack    = (sc == 2'b10);
   end

   // disp_off dominates a simultaneous disp_on
   always_ff @(posedge clk) begin
      if (reset)
         pending <= 1'b0;
      else if (disp_off)
         pending <= 1'b0;
      else if (disp_on)
         pending <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         ack_cnt         <= 3'd0;
         hcount          <= 4'd0;
         vcount          <= 9'd0;
         dma_out_n       <= 1'b1;
         int_req         <= 1'b0;
         efx_n           <= 1'b1;
         byte_valid      <= 1'b0;
         byte_data       <= 8'd0;
         byte_col        <= 3'd0;
         byte_row        <= 7'd0;
         line_start      <= 1'b0;
         frame_start     <= 1'b0;
         display_enabled <= 1'b0;
         dma_short       <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce) begin
            hcount          <= h_nxt;
            vcount          <= v_nxt;
            display_enabled <= de_nxt;
            line_start      <= wrap;
            frame_start     <= wrap && (v_nxt == 9'd0);
            // flags track the counter values being loaded this cycle
            int_req <= de_nxt && (v_nxt >= INT_LO) && (v_nxt < V_FIRST);
            efx_n   <= !(((v_nxt >= EF1_LO) && (v_nxt < V_FIRST)) ||
                         ((v_nxt >= EF2_LO) && (v_nxt < V_END)));
            unique case (state)
               IDLE: begin
                  if ((hcount == H_DMA) && active) begin
                     ack_cnt   <= 3'd0;
                     dma_out_n <= 1'b0;
                     state     <= REQ;
                  end
               end
               REQ: begin
                  if (ack) begin
                     byte_valid <= 1'b1;
                     byte_data  <= data_in;
                     byte_col   <= ack_cnt;
                     byte_row   <= vcount[6:0] - ROW_OFS;
                     ack_cnt    <= ack_cnt + 3'd1;
                  end
                  if (ack && (ack_cnt == ACK_LAST)) begin
                     dma_out_n <= 1'b1;
                     state     <= IDLE;
                  end else if (hcount == H_LAST) begin
                     dma_short <= 1'b1;
                     dma_out_n <= 1'b1;
                     state     <= IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Directed bench for pixie_dma_scheduler: timing, INT/EFx windows,
// DMA byte delivery, short lines, display enable and reset recovery.
module tb_pixie_dma_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b0;
   logic [1:0] sc = 2'b00;
   logic       disp_on = 1'b0;
   logic       disp_off = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       dma_out_n;
   logic       int_req;
   logic       efx_n;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic [2:0] byte_col;
   logic [6:0] byte_row;
   logic       line_start;
   logic       frame_start;
   logic [3:0] hcount;
   logic [8:0] vcount;
   logic       display_enabled;
   logic       dma_short;

   int total = 0;
   int bad = 0;
   int mh = 0;
   int mv = 0;
   int nbytes = 0;
   int nlow = 0;
   int nls = 0;
   int nfs = 0;
   int nint = 0;

   pixie_dma_scheduler dut (
      .clk(clk), .reset(reset), .ce(ce), .sc(sc),
      .disp_on(disp_on), .disp_off(disp_off), .data_in(data_in),
      .dma_out_n(dma_out_n), .int_req(int_req), .efx_n(efx_n),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_col(byte_col), .byte_row(byte_row),
      .line_start(line_start), .frame_start(frame_start),
      .hcount(hcount), .vcount(vcount),
      .display_enabled(display_enabled), .dma_short(dma_short)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one machine cycle; outputs are sampled on the negedge after the ce edge
   task automatic step(input int gap, input bit ack, input logic [7:0] d);
      @(negedge clk);
      ce = 1'b1;
      sc = ack ? 2'b10 : 2'b00;
      data_in = d;
      @(negedge clk);
      ce = 1'b0;
      sc = 2'b00;
      if (mh == 13) begin
         mh = 0;
         mv = (mv == 261) ? 0 : mv + 1;
      end else begin
         mh++;
      end
      if (byte_valid) nbytes++;
      if (!dma_out_n) nlow++;
      if (line_start) nls++;
      if (frame_start) nfs++;
      if (int_req) nint++;
      repeat (gap) @(negedge clk);
   endtask

   task automatic run_to(input int v, input int h, input bit auto_ack);
      while (!(mv == v && mh == h))
         step(0, auto_ack && !dma_out_n, 8'($urandom));
   endtask

   task automatic pulse(input bit on, input bit off);
      @(negedge clk);
      disp_on = on;
      disp_off = off;
      @(negedge clk);
      disp_on = 1'b0;
      disp_off = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_dma_out_n", dma_out_n, 1);
      chk("rst_int_req", int_req, 0);
      chk("rst_efx_n", efx_n, 1);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_hv", {hcount, vcount}, 0);
      chk("rst_flags", {line_start, frame_start, display_enabled, dma_short}, 0);
      reset = 1'b0;

      // a full frame, display never enabled, ce every 8 clks
      for (int i = 0; i < 262 * 14; i++) begin
         step(6, 1'b0, 8'h00);
         chk("f1_efx_n", efx_n,
             ((mv >= 60 && mv <= 63) || (mv >= 188 && mv <= 191)) ? 0 : 1);
         if (mh == 0) chk("f1_vcount", vcount, mv);
      end
      chk("f1_no_dma", nlow, 0);
      chk("f1_no_int", nint, 0);
      chk("f1_line_starts", nls, 262);
      chk("f1_frame_starts", nfs, 1);
      chk("f1_hv_wrapped", {hcount, vcount}, 0);
      chk("ce0_pulses_low", {frame_start, line_start, byte_valid}, 0);

      pulse(1'b1, 1'b0);
      run_to(61, 0, 1'b1);
      chk("int_v61", int_req, 0);
      chk("de_on", display_enabled, 1);
      run_to(62, 0, 1'b1);
      chk("int_v62", int_req, 1);
      run_to(63, 5, 1'b1);
      chk("int_v63", int_req, 1);
      run_to(64, 0, 1'b1);
      chk("int_v64", int_req, 0);

      run_to(64, 2, 1'b0);
      chk("l64_no_req_yet", dma_out_n, 1);
      step(0, 1'b0, 8'h00);
      chk("l64_req_h2", dma_out_n, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1'b1, 8'(i + 1));
         chk("l64_valid", byte_valid, 1);
         chk("l64_data", byte_data, i + 1);
         chk("l64_col", byte_col, i);
         chk("l64_row", byte_row, 0);
         chk("l64_dma_out_n", dma_out_n, (i == 7) ? 1 : 0);
      end
      @(negedge clk);
      chk("l64_valid_drop", byte_valid, 0);

      // disable mid-line 70: line completes, line 71 idle
      run_to(70, 0, 1'b1);
      nbytes = 0;
      run_to(70, 6, 1'b1);
      pulse(1'b0, 1'b1);
      run_to(71, 0, 1'b1);
      chk("l70_bytes", nbytes, 8);
      chk("l71_de_off", display_enabled, 0);
      nlow = 0;
      nbytes = 0;
      run_to(72, 0, 1'b1);
      chk("l71_no_req", nlow, 0);
      chk("l71_no_bytes", nbytes, 0);
      pulse(1'b1, 1'b1);
      run_to(73, 0, 1'b1);
      chk("both_strobes_off", display_enabled, 0);
      pulse(1'b1, 1'b0);
      run_to(74, 0, 1'b1);
      chk("reenabled", display_enabled, 1);

      // reset after the 3rd ack of line 80
      run_to(80, 6, 1'b1);
      chk("l80_req_open", dma_out_n, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_dma", dma_out_n, 1);
      chk("mid_rst_hv", {hcount, vcount}, 0);
      chk("mid_rst_valid", byte_valid, 0);
      chk("mid_rst_de", display_enabled, 0);
      reset = 1'b0;
      mh = 0;
      mv = 0;
      nbytes = 0;
      repeat (6) step(0, 1'b1, 8'hFF);
      chk("post_rst_no_bytes", nbytes, 0);

      // short line 100, then a normal line 101
      pulse(1'b1, 1'b0);
      run_to(100, 3, 1'b1);
      chk("pre100_short", dma_short, 0);
      chk("l100_req", dma_out_n, 0);
      for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'h30 + i));
      run_to(100, 13, 1'b0);
      chk("l100_h13_req", dma_out_n, 0);
      chk("l100_h13_short", dma_short, 0);
      step(0, 1'b0, 8'h00);
      chk("l100_short", dma_short, 1);
      chk("l100_released", dma_out_n, 1);
      run_to(101, 3, 1'b0);
      chk("l101_req", dma_out_n, 0);
      step(0, 1'b1, 8'hA5);
      chk("l101_valid", byte_valid, 1);
      chk("l101_col", byte_col, 0);
      chk("l101_row", byte_row, 37);
      chk("l101_data", byte_data, 8'hA5);
      run_to(102, 0, 1'b1);
      chk("short_sticky", dma_short, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
